// File: rtl/ray_sweep_sequencer.sv
// ray_sweep_sequencer: frame-level ray sweep for the horizontal wall-intersection
// calculator. Latches the pose at frame start, issues one calculation per screen
// column and forwards each column result downstream over a valid/ready handshake.
// Optional macro RAY_TIMEOUT_EN adds a WAIT-state watchdog that aborts a silent
// calculation after TIMEOUT_CYCLES and emits an empty (no-hit) column instead.
module ray_sweep_sequencer #(
    parameter int NUM_COLS       = 160,
    parameter int ANGLE_STEP     = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_frame,
    input  logic [11:0]                 playerX,
    input  logic [11:0]                 playerY,
    input  logic [11:0]                 player_angle,
    output logic                        begin_calc,
    output logic [11:0]                 ray_X,
    output logic [11:0]                 ray_Y,
    output logic [11:0]                 alpha,
    input  logic                        calc_done,
    input  logic [11:0]                 wall_X,
    input  logic [11:0]                 wall_Y,
    input  logic                        wall_found,
    output logic                        calc_abort,
    output logic                        col_valid,
    input  logic                        col_ready,
    output logic [$clog2(NUM_COLS)-1:0] col_index,
    output logic [11:0]                 col_wall_X,
    output logic [11:0]                 col_wall_Y,
    output logic                        col_hit,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int IW = $clog2(NUM_COLS);

    // Half the field of view in angle units, reduced to the 12-bit angle circle.
    localparam logic [11:0]   HALF_SPAN = 12'(((NUM_COLS / 2) * ANGLE_STEP) % 4096);
    localparam logic [11:0]   STEP      = 12'(ANGLE_STEP % 4096);
    localparam logic [IW-1:0] LAST_COL  = IW'(NUM_COLS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [11:0]   ray_x_q, ray_x_d;
    logic [11:0]   ray_y_q, ray_y_d;
    logic [11:0]   alpha_q, alpha_d;
    logic [IW-1:0] col_index_q, col_index_d;
    logic [11:0]   col_wall_x_q, col_wall_x_d;
    logic [11:0]   col_wall_y_q, col_wall_y_d;
    logic          col_hit_q, col_hit_d;
    logic          timeout;

`ifdef RAY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_q, wd_d;

    // Watchdog counts WAIT cycles; it is zero on every entry to WAIT because it
    // is held clear in all other states.
    always_comb begin
        wd_d = '0;
        if (state_q == S_WAIT) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout    = (state_q == S_WAIT) && (wd_q == TW'(TIMEOUT_CYCLES - 1));
    // A result arriving in the expiry cycle wins, so no abort is sent then.
    assign calc_abort = timeout && !calc_done;
`else
    assign timeout    = 1'b0;
    assign calc_abort = 1'b0;
`endif

    // Sweep sequencing: pose latch, per-column issue/wait/emit and angle stepping.
    always_comb begin
        state_d      = state_q;
        ray_x_d      = ray_x_q;
        ray_y_d      = ray_y_q;
        alpha_d      = alpha_q;
        col_index_d  = col_index_q;
        col_wall_x_d = col_wall_x_q;
        col_wall_y_d = col_wall_y_q;
        col_hit_d    = col_hit_q;
        case (state_q)
            S_IDLE: begin
                if (start_frame) begin
                    state_d     = S_ISSUE;
                    ray_x_d     = playerX;
                    ray_y_d     = playerY;
                    alpha_d     = player_angle - HALF_SPAN;
                    col_index_d = '0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (calc_done) begin
                    state_d      = S_EMIT;
                    col_wall_x_d = wall_X;
                    col_wall_y_d = wall_Y;
                    col_hit_d    = wall_found;
                end else if (timeout) begin
                    state_d      = S_EMIT;
                    col_wall_x_d = '0;
                    col_wall_y_d = '0;
                    col_hit_d    = 1'b0;
                end
            end
            S_EMIT: begin
                if (col_ready) begin
                    if (col_index_q == LAST_COL) begin
                        // Last column: angle and index keep their final values.
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_ISSUE;
                        alpha_d     = alpha_q + STEP;
                        col_index_d = col_index_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ray_x_q      <= '0;
            ray_y_q      <= '0;
            alpha_q      <= '0;
            col_index_q  <= '0;
            col_wall_x_q <= '0;
            col_wall_y_q <= '0;
            col_hit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ray_x_q      <= ray_x_d;
            ray_y_q      <= ray_y_d;
            alpha_q      <= alpha_d;
            col_index_q  <= col_index_d;
            col_wall_x_q <= col_wall_x_d;
            col_wall_y_q <= col_wall_y_d;
            col_hit_q    <= col_hit_d;
        end
    end

    assign begin_calc = (state_q == S_ISSUE);
    assign col_valid  = (state_q == S_EMIT);
    assign frame_done = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign ray_X      = ray_x_q;
    assign ray_Y      = ray_y_q;
    assign alpha      = alpha_q;
    assign col_index  = col_index_q;
    assign col_wall_X = col_wall_x_q;
    assign col_wall_Y = col_wall_y_q;
    assign col_hit    = col_hit_q;

endmodule

// File: tb/tb_ray_sweep_sequencer.sv
// Testbench for ray_sweep_sequencer: drives whole frames against a behavioural
// calculator/renderer and checks every column against angle arithmetic.
module tb_ray_sweep_sequencer;

    localparam int NC = 160;
    localparam int AS = 6;
    localparam int IW = $clog2(NC);
`ifdef RAY_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          start_frame;
    logic [11:0]   playerX, playerY, player_angle;
    logic          begin_calc;
    logic [11:0]   ray_X, ray_Y, alpha;
    logic          calc_done;
    logic [11:0]   wall_X, wall_Y;
    logic          wall_found;
    logic          calc_abort;
    logic          col_valid;
    logic          col_ready;
    logic [IW-1:0] col_index;
    logic [11:0]   col_wall_X, col_wall_Y;
    logic          col_hit;
    logic          busy;
    logic          frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    ray_sweep_sequencer #(
        .NUM_COLS(NC), .ANGLE_STEP(AS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .start_frame(start_frame),
        .playerX(playerX), .playerY(playerY), .player_angle(player_angle),
        .begin_calc(begin_calc), .ray_X(ray_X), .ray_Y(ray_Y), .alpha(alpha),
        .calc_done(calc_done), .wall_X(wall_X), .wall_Y(wall_Y),
        .wall_found(wall_found), .calc_abort(calc_abort),
        .col_valid(col_valid), .col_ready(col_ready), .col_index(col_index),
        .col_wall_X(col_wall_X), .col_wall_Y(col_wall_Y), .col_hit(col_hit),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    // Reference: angle of column k for a frame started at view angle ang.
    function automatic logic [11:0] exp_alpha(input int ang, input int k);
        int a;
        a = (ang - (NC / 2) * AS + k * AS) % 4096;
        if (a < 0) a += 4096;
        return 12'(a);
    endfunction

    // Runs one frame. lat=0 picks a random calculator latency per column;
    // negative column arguments disable stall / poke / reset-abort / silence.
    task automatic run_frame(input logic [11:0] px, input logic [11:0] py,
                             input logic [11:0] ang, input int lat,
                             input int stall_col, input int stall_len,
                             input int poke_col, input int abort_col,
                             input int silent_col, input string tag);
        int k = 0; int bc = 0; int fd = 0; int ab = 0; int cnt = 0;
        int stall = 0; int cyc = 0; int exp_ab;
        bit done = 0; bit pending = 0;
        logic [24:0] exp_res = '0;
        logic [11:0] ea;
        @(negedge clock);
        playerX = px; playerY = py; player_angle = ang; start_frame = 1'b1; col_ready = 1'b1;
        @(negedge clock);
        start_frame = 1'b0;
        playerX = 12'($urandom); playerY = 12'($urandom); player_angle = 12'($urandom);
        while (!done && cyc < 20000) begin
            cyc++;
            start_frame = 1'b0;
            ea = exp_alpha(int'(ang), (k < NC) ? k : NC - 1);
            if (calc_abort) ab++;
            if (begin_calc) begin
                bc++;
                n_checks++;
                if ({busy, ray_X, ray_Y, alpha, col_index} !== {1'b1, px, py, ea, IW'(k)})
                    $display("FAIL %s issue col %0d: got busy/x/y/alpha/idx=%h required %h", tag, k,
                             {busy, ray_X, ray_Y, alpha, col_index}, {1'b1, px, py, ea, IW'(k)});
                else n_pass++;
                cnt = (lat > 0) ? lat : int'($urandom_range(1, 6));
                if (k == silent_col) begin
                    cnt = -1;
                    exp_res = '0;
                end else if (cnt >= 2 && $urandom_range(0, 1) == 1) begin
                    // stray strobe during ISSUE must be ignored
                    calc_done = 1'b1; wall_X = 12'($urandom); wall_Y = 12'($urandom); wall_found = 1'b1;
                end
                if (k == poke_col) begin
                    start_frame = 1'b1;
                    playerX = 12'($urandom); playerY = 12'($urandom); player_angle = 12'($urandom);
                end
            end else if (cnt > 0) begin
                if (k == abort_col) begin
                    reset = 1'b1;
                    #1;
                    n_checks++;
                    if ({begin_calc, ray_X, ray_Y, alpha, calc_abort, col_valid, col_index,
                         col_wall_X, col_wall_Y, col_hit, busy, frame_done} !== '0)
                        $display("FAIL %s reset outputs: got %h required 0", tag,
                                 {begin_calc, ray_X, ray_Y, alpha, calc_abort, col_valid, col_index,
                                  col_wall_X, col_wall_Y, col_hit, busy, frame_done});
                    else n_pass++;
                    n_checks++;
                    if (fd !== 0 || ab !== 0)
                        $display("FAIL %s pulses before reset: got frame_done=%0d abort=%0d required 0/0", tag, fd, ab);
                    else n_pass++;
                    calc_done = 1'b0;
                    @(negedge clock);
                    reset = 1'b0;
                    return;
                end
                calc_done = 1'b0;
                cnt--;
                if (cnt == 0) begin
                    wall_X = 12'($urandom); wall_Y = 12'($urandom); wall_found = 1'($urandom);
                    calc_done = 1'b1;
                    exp_res = {wall_X, wall_Y, wall_found};
                end
            end else begin
                calc_done = 1'b0;
            end
            if (col_valid) begin
                n_checks++;
                if ({col_index, alpha, col_wall_X, col_wall_Y, col_hit, begin_calc} !== {IW'(k), ea, exp_res, 1'b0})
                    $display("FAIL %s emit col %0d: got idx/alpha/wx/wy/hit/bc=%h required %h", tag, k,
                             {col_index, alpha, col_wall_X, col_wall_Y, col_hit, begin_calc},
                             {IW'(k), ea, exp_res, 1'b0});
                else n_pass++;
                if (!pending) begin
                    pending = 1;
                    stall = (k == stall_col) ? stall_len : 0;
                end
                if (stall > 0) begin
                    col_ready = 1'b0;
                    stall--;
                end else begin
                    col_ready = 1'b1;
                    pending = 0;
                    k++;
                end
            end
            if (frame_done) begin
                fd++;
                n_checks++;
                if ({alpha, col_index, busy} !== {exp_alpha(int'(ang), NC - 1), IW'(NC - 1), 1'b1})
                    $display("FAIL %s done state: got alpha/idx/busy=%h required %h", tag,
                             {alpha, col_index, busy}, {exp_alpha(int'(ang), NC - 1), IW'(NC - 1), 1'b1});
                else n_pass++;
                done = 1;
            end
            @(negedge clock);
        end
        calc_done = 1'b0;
        col_ready = 1'b1;
`ifdef RAY_TIMEOUT_EN
        exp_ab = (silent_col >= 0) ? 1 : 0;
`else
        exp_ab = 0;
`endif
        n_checks++;
        if (!done) $display("FAIL %s frame budget: got no frame_done within %0d cycles", tag, cyc);
        else n_pass++;
        n_checks++;
        if ({busy, frame_done} !== 2'b00)
            $display("FAIL %s idle after done: got busy/frame_done=%b required 00", tag, {busy, frame_done});
        else n_pass++;
        n_checks++;
        if (bc !== NC || fd !== 1 || ab !== exp_ab)
            $display("FAIL %s pulse counts: got begin_calc=%0d frame_done=%0d abort=%0d required %0d/1/%0d",
                     tag, bc, fd, ab, NC, exp_ab);
        else n_pass++;
        $display("frame %s: %0d begin_calc, %0d frame_done, %0d abort, %0d cycles", tag, bc, fd, ab, cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1; start_frame = 1'b0; calc_done = 1'b0; col_ready = 1'b1;
        playerX = '0; playerY = '0; player_angle = '0; wall_X = '0; wall_Y = '0; wall_found = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({begin_calc, ray_X, ray_Y, alpha, calc_abort, col_valid, col_index,
             col_wall_X, col_wall_Y, col_hit, busy, frame_done} !== '0)
            $display("FAIL reset outputs: got %h required 0",
                     {begin_calc, ray_X, ray_Y, alpha, calc_abort, col_valid, col_index,
                      col_wall_X, col_wall_Y, col_hit, busy, frame_done});
        else n_pass++;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({busy, begin_calc} !== 2'b00) $display("FAIL idle hold: got busy/begin_calc=%b required 00", {busy, begin_calc});
        else n_pass++;
        $display("reset: outputs checked");
    endtask

    task automatic test_basic_sweep();
        run_frame(12'd100, 12'd200, 12'd1000, 5, -1, 0, -1, -1, -1, "basic");
    endtask

    task automatic test_wrap();
        run_frame(12'($urandom), 12'($urandom), 12'd100, 0, -1, 0, -1, -1, -1, "wrap");
    endtask

    task automatic test_stall();
        run_frame(12'($urandom), 12'($urandom), 12'd2000, 3, 7, 20, -1, -1, -1, "stall");
    endtask

    task automatic test_midframe_poke();
        run_frame(12'd321, 12'd654, 12'd4000, 0, -1, 0, 40, -1, -1, "poke");
    endtask

    task automatic test_reset_midframe();
        run_frame(12'($urandom), 12'($urandom), 12'($urandom), 2, -1, 0, -1, 50, -1, "abort");
        run_frame(12'($urandom), 12'($urandom), 12'($urandom), 0, -1, 0, -1, -1, -1, "restart");
    endtask

`ifdef RAY_TIMEOUT_EN
    task automatic test_timeout();
        run_frame(12'($urandom), 12'($urandom), 12'($urandom), 0, -1, 0, -1, -1, 3, "timeout");
    endtask
`endif

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++)
            run_frame(12'($urandom), 12'($urandom), 12'($urandom), 0,
                      int'($urandom_range(0, NC - 1)), int'($urandom_range(1, 8)), -1, -1, -1, "b2b");
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_wrap();
        test_stall();
        test_midframe_poke();
        test_reset_midframe();
`ifdef RAY_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
